// File: rtl/cpu_pipe_pkg.sv
// Shared types and encodings for the pipeline memory stage.
package cpu_pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Bit positions inside the 2-bit M control field
    localparam int M_READ  = 1;
    localparam int M_WRITE = 0;

    localparam logic [1:0] MEMOP_NONE = 2'b00;
    localparam logic [1:0] MEMOP_LD   = 2'b10;
    localparam logic [1:0] MEMOP_ST   = 2'b01;

    function automatic logic is_mem_op(input logic [1:0] m);
        return (m == MEMOP_LD) || (m == MEMOP_ST);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack handshake between the memory stage and the data memory.
interface mem_stage_ctrl_if #(
    parameter int DW = 64
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank: loads a result or inserts a bubble each edge.
module mem_wb_reg #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          bubble,
    input  logic [DW-1:0] alu_res,
    input  logic [DW-1:0] mem_data,
    input  logic [RW-1:0] rd,
    input  logic          wb,
    input  logic          mem_to_reg,
    output logic          valid,
    output logic [DW-1:0] alu_reg,
    output logic [DW-1:0] mem_reg,
    output logic [RW-1:0] rd_reg,
    output logic          wb_reg,
    output logic          mtr_reg
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            alu_reg <= '0;
            mem_reg <= '0;
            rd_reg  <= '0;
            wb_reg  <= 1'b0;
            mtr_reg <= 1'b0;
        end else if (bubble) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            // A bubble only needs its control bits cleared; the data fields are don't-care.
            valid   <= 1'b0;
            wb_reg  <= 1'b0;
            mtr_reg <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            alu_reg <= alu_res;
            mem_reg <= mem_data;
            rd_reg  <= rd;
            wb_reg  <= wb;
            mtr_reg <= mem_to_reg;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores over req/ack, stalls upstream
// while an access is outstanding, and feeds the MEM/WB register.
module mem_stage_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int DW       = 64,
    parameter int RW       = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic [DW-1:0]          ALUresult,
    input  logic [DW-1:0]          WriteData,
    input  logic [RW-1:0]          Rd,
    input  logic                   WB,
    input  logic [1:0]             M,
    output logic                   stall,
    mem_stage_ctrl_if.master       dmem,
    output logic                   wb_valid,
    output logic [DW-1:0]          MemData_out,
    output logic [DW-1:0]          ALUresult_out,
    output logic [RW-1:0]          Rd_out,
    output logic                   WB_out,
    output logic                   MemToReg_out,
    output logic                   err
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

    mem_state_t    state, next_state;
    logic [CW-1:0] wait_cnt;
    logic          req_q, we_q, rd_op_q, wb_q, err_q;
    logic [DW-1:0] addr_q, wdata_q;
    logic [RW-1:0] rd_q;

    logic          launch, illegal, timeout, wb_load;
    logic [DW-1:0] wb_alu, wb_mem;
    logic [RW-1:0] wb_rd;
    logic          wb_wb, wb_mtr;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        next_state = state;
        stall      = 1'b0;
        launch     = 1'b0;
        illegal    = 1'b0;
        timeout    = 1'b0;
        wb_load    = 1'b0;
        wb_alu     = ALUresult;
        wb_mem     = '0;
        wb_rd      = Rd;
        wb_wb      = WB;
        wb_mtr     = 1'b0;

        unique case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (M == MEMOP_NONE) begin
                        wb_load = 1'b1;
                    end else if (is_mem_op(M)) begin
                        stall      = 1'b1;
                        launch     = 1'b1;
                        next_state = WAIT;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            WAIT: begin
                wb_alu = addr_q;
                wb_rd  = rd_q;
                if (dmem.dmem_ack) begin
                    wb_load    = 1'b1;
                    wb_wb      = wb_q;
                    wb_mtr     = rd_op_q;
                    wb_mem     = rd_op_q ? dmem.dmem_rdata : '0;
                    next_state = IDLE;
                end else if (wait_cnt == LAST_CNT) begin
                    // Abort: retire a harmless non-writing entry and release the pipeline
                    timeout    = 1'b1;
                    wb_load    = 1'b1;
                    wb_wb      = 1'b0;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            rd_op_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;

            if (launch) begin
                req_q   <= 1'b1;
                we_q    <= M[M_WRITE];
                addr_q  <= ALUresult;
                wdata_q <= WriteData;
                rd_q    <= Rd;
                wb_q    <= WB;
                rd_op_q <= M[M_READ];
            end else if (state == WAIT && next_state == IDLE) begin
                req_q <= 1'b0;
            end

            if (state == WAIT && next_state == WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (illegal || timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign err             = err_q;

    mem_wb_reg #(
        .DW (DW),
        .RW (RW)
    ) u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .load       (wb_load),
        .bubble     (~wb_load),
        .alu_res    (wb_alu),
        .mem_data   (wb_mem),
        .rd         (wb_rd),
        .wb         (wb_wb),
        .mem_to_reg (wb_mtr),
        .valid      (wb_valid),
        .alu_reg    (ALUresult_out),
        .mem_reg    (MemData_out),
        .rd_reg     (Rd_out),
        .wb_reg     (WB_out),
        .mtr_reg    (MemToReg_out)
    );

endmodule
